// File: rtl/rr_credit_dispatcher_if.sv
// Handshake and credit bundle between an upstream producer and the round-robin
// credit dispatcher.
interface rr_credit_dispatcher_if #(
  parameter int NUM_OUT = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 2
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [DATA_W-1:0]        in_data_i;
  logic [NUM_OUT-1:0]       out_valid_o;
  logic [DATA_W-1:0]        out_data_o;
  logic [NUM_OUT-1:0]       credit_ret_i;
  logic [NUM_OUT*CNT_W-1:0] credit_cnt_o;
  logic                     err_o;

  modport master (
    output in_valid_i, in_data_i, credit_ret_i,
    input  in_ready_o, out_valid_o, out_data_o, credit_cnt_o, err_o
  );

  modport slave (
    input  in_valid_i, in_data_i, credit_ret_i,
    output in_ready_o, out_valid_o, out_data_o, credit_cnt_o, err_o
  );
endinterface

// File: rtl/rr_credit_dispatcher.sv
// 1-to-N round-robin dispatcher: each accepted word goes to the next port (in
// rotating order) that still holds a credit, delivered one cycle later.
module rr_credit_dispatcher #(
  parameter  int NUM_OUT = 4,
  parameter  int DATA_W  = 32,
  parameter  int CREDITS = 2,
  localparam int CNT_W   = $clog2(CREDITS + 1)
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  rr_credit_dispatcher_if.slave bus
);
  localparam int W2 = 2 * NUM_OUT;

  logic [CNT_W-1:0]   r_credit [NUM_OUT];
  logic [NUM_OUT-1:0] r_base;
  logic [NUM_OUT-1:0] r_outValid;
  logic [DATA_W-1:0]  r_outData;
  logic               r_err;

  logic [NUM_OUT-1:0] w_eligible;
  logic               w_ready;
  logic               w_fire;
  logic [W2-1:0]      w_masked;
  logic [W2-1:0]      w_lowest;
  logic [NUM_OUT-1:0] w_target;
  logic [NUM_OUT-1:0] w_dec;

  always_comb begin
    w_eligible = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_eligible[k] = (r_credit[k] != '0);
    end
  end

  assign w_ready = |w_eligible;
  assign w_fire  = bus.in_valid_i & w_ready;

  // Lower copy keeps only ports at or above base; the upper copy supplies the
  // wrap-around, so the lowest set bit of the doubled vector is the winner.
  assign w_masked = {w_eligible, w_eligible & ~(r_base - NUM_OUT'(1))};
  assign w_lowest = w_masked & (~w_masked + W2'(1));
  assign w_target = w_lowest[NUM_OUT-1:0] | w_lowest[W2-1:NUM_OUT];
  assign w_dec    = w_fire ? w_target : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outValid <= '0;
      r_outData  <= '0;
      r_base     <= NUM_OUT'(1);
    end else begin
      r_outValid <= w_dec;
      if (w_fire) begin
        r_outData <= bus.in_data_i;
        r_base    <= {w_target[NUM_OUT-2:0], w_target[NUM_OUT-1]};
      end
    end
  end

  // A simultaneous take and return nets to zero; a return into a full counter
  // is dropped and latched as a sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        r_credit[k] <= CNT_W'(CREDITS);
      end
      r_err <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        case ({w_dec[k], bus.credit_ret_i[k]})
          2'b10: r_credit[k] <= r_credit[k] - CNT_W'(1);
          2'b01: begin
            if (r_credit[k] == CNT_W'(CREDITS)) begin
              r_err <= 1'b1;
            end else begin
              r_credit[k] <= r_credit[k] + CNT_W'(1);
            end
          end
          default: r_credit[k] <= r_credit[k];
        endcase
      end
    end
  end

  always_comb begin
    bus.credit_cnt_o = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      bus.credit_cnt_o[k*CNT_W +: CNT_W] = r_credit[k];
    end
  end

  assign bus.in_ready_o  = w_ready;
  assign bus.out_valid_o = r_outValid;
  assign bus.out_data_o  = r_outData;
  assign bus.err_o       = r_err;
endmodule

// File: tb/tb_rr_credit_dispatcher.sv
// Directed bench for rr_credit_dispatcher: rotation, credit skipping, net-zero
// take/return, overflow error and mid-operation reset, plus per-cycle monitors.
module tb_rr_credit_dispatcher;
  localparam int NUM_OUT = 4;
  localparam int DATA_W  = 32;
  localparam int CREDITS = 2;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   expTotal    = NUM_OUT * CREDITS;
  int   monSum;

  always #5 clk = ~clk;

  rr_credit_dispatcher_if #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  rr_credit_dispatcher #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CREDITS(CREDITS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  function automatic logic [CNT_W-1:0] getCnt(input int k);
    return bus.credit_cnt_o[k*CNT_W +: CNT_W];
  endfunction

  // Independent credit-conservation model: every accepted word costs one
  // credit, every return gives one back.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expTotal = NUM_OUT * CREDITS;
    end else begin
      expTotal = expTotal + $countones(bus.credit_ret_i)
                 - ((bus.in_valid_i && bus.in_ready_o) ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      monSum = 0;
      for (int k = 0; k < NUM_OUT; k++) monSum += int'(getCnt(k));
      nCompared++;
      if (!$onehot0(bus.out_valid_o)) begin
        nMismatched++;
        $display("[TB] FAIL mon_onehot0: out_valid=%b not onehot0", bus.out_valid_o);
      end
      if (!bus.err_o) begin
        nCompared++;
        if (monSum != expTotal) begin
          nMismatched++;
          $display("[TB] FAIL mon_conservation: credit sum=%0d expected %0d", monSum, expTotal);
        end
      end
      if (monSum == 0) begin
        nCompared++;
        if (bus.in_ready_o !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL mon_no_credit_ready: in_ready=%b expected 0", bus.in_ready_o);
        end
      end
    end
  end

  task automatic doReset();
    rst_n = 1'b0;
    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = '0;
    bus.credit_ret_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sendWord(input logic [DATA_W-1:0] d, input logic [NUM_OUT-1:0] ret);
    bus.in_valid_i   = 1'b1;
    bus.in_data_i    = d;
    bus.credit_ret_i = ret;
    @(negedge clk);
    bus.in_valid_i   = 1'b0;
    bus.credit_ret_i = '0;
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clk);
    nCompared++;
    if (bus.in_ready_o !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.in_ready_o);
    end
    nCompared++;
    if (bus.out_valid_o !== 4'b0000) begin
      nMismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0000", bus.out_valid_o);
    end
    nCompared++;
    if (bus.out_data_o !== 32'h0) begin
      nMismatched++; $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data_o);
    end
    nCompared++;
    if (bus.err_o !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err_o);
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      nCompared++;
      if (getCnt(k) !== 2'd2) begin
        nMismatched++; $display("[TB] FAIL reset_credit%0d: got %0d expected 2", k, getCnt(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_OUT-1:0] expV [8];
    expV = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    doReset();
    for (int i = 0; i < 8; i++) begin
      sendWord(32'hA0 + 32'(i), '0);
      nCompared++;
      if (bus.out_valid_o !== expV[i] || bus.out_data_o !== 32'hA0 + 32'(i)) begin
        nMismatched++;
        $display("[TB] FAIL b2b_word%0d: got valid=%b data=%h expected valid=%b data=%h",
                 i, bus.out_valid_o, bus.out_data_o, expV[i], 32'hA0 + 32'(i));
      end
    end
    nCompared++;
    if (bus.in_ready_o !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL b2b_ready_after8: got %b expected 0", bus.in_ready_o);
    end
    sendWord(32'hDEAD, '0);
    nCompared++;
    if (bus.out_valid_o !== 4'b0000 || bus.out_data_o !== 32'hA7) begin
      nMismatched++;
      $display("[TB] FAIL b2b_no_credit_hold: got valid=%b data=%h expected valid=0000 data=000000a7",
               bus.out_valid_o, bus.out_data_o);
    end
  endtask

  task automatic test_skip_port();
    logic [NUM_OUT-1:0] expV [4];
    logic [CNT_W-1:0]   expC [NUM_OUT];
    expV = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};
    expC = '{2'd0, 2'd0, 2'd0, 2'd1};
    doReset();
    for (int i = 0; i < 6; i++) sendWord(32'hB0 + 32'(i), '0);
    bus.credit_ret_i = 4'b1101;
    @(negedge clk);
    bus.credit_ret_i = '0;
    nCompared++;
    if (getCnt(1) !== 2'd0 || getCnt(0) !== 2'd1) begin
      nMismatched++;
      $display("[TB] FAIL skip_setup: got cnt0=%0d cnt1=%0d expected cnt0=1 cnt1=0", getCnt(0), getCnt(1));
    end
    for (int i = 0; i < 4; i++) begin
      sendWord(32'hC0 + 32'(i), '0);
      nCompared++;
      if (bus.out_valid_o !== expV[i] || bus.out_data_o !== 32'hC0 + 32'(i)) begin
        nMismatched++;
        $display("[TB] FAIL skip_word%0d: got valid=%b data=%h expected valid=%b data=%h",
                 i, bus.out_valid_o, bus.out_data_o, expV[i], 32'hC0 + 32'(i));
      end
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      nCompared++;
      if (getCnt(k) !== expC[k]) begin
        nMismatched++; $display("[TB] FAIL skip_credit%0d: got %0d expected %0d", k, getCnt(k), expC[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    doReset();
    for (int i = 0; i < 6; i++) sendWord(32'hD0 + 32'(i), '0);
    nCompared++;
    if (getCnt(2) !== 2'd1) begin
      nMismatched++; $display("[TB] FAIL simul_setup: got cnt2=%0d expected 1", getCnt(2));
    end
    sendWord(32'hD6, 4'b0100);
    nCompared++;
    if (bus.out_valid_o !== 4'b0100 || bus.out_data_o !== 32'hD6) begin
      nMismatched++;
      $display("[TB] FAIL simul_target: got valid=%b data=%h expected valid=0100 data=000000d6",
               bus.out_valid_o, bus.out_data_o);
    end
    nCompared++;
    if (getCnt(2) !== 2'd1 || bus.err_o !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL simul_net_zero: got cnt2=%0d err=%b expected cnt2=1 err=0", getCnt(2), bus.err_o);
    end
  endtask

  task automatic test_overflow();
    doReset();
    bus.credit_ret_i = 4'b1000;
    @(negedge clk);
    bus.credit_ret_i = '0;
    nCompared++;
    if (getCnt(3) !== 2'd2 || bus.err_o !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL ovf_set: got cnt3=%0d err=%b expected cnt3=2 err=1", getCnt(3), bus.err_o);
    end
    repeat (3) @(negedge clk);
    nCompared++;
    if (bus.err_o !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL ovf_sticky: got err=%b expected 1", bus.err_o);
    end
    sendWord(32'hE1, '0);
    nCompared++;
    if (bus.out_valid_o !== 4'b0001 || bus.out_data_o !== 32'hE1 || getCnt(0) !== 2'd1) begin
      nMismatched++;
      $display("[TB] FAIL ovf_dispatch: got valid=%b data=%h cnt0=%0d expected valid=0001 data=000000e1 cnt0=1",
               bus.out_valid_o, bus.out_data_o, getCnt(0));
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'h66;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    nCompared++;
    if (bus.out_valid_o !== 4'b0001) begin
      nMismatched++; $display("[TB] FAIL rmid_pulse: got %b expected 0001", bus.out_valid_o);
    end
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (bus.out_valid_o !== 4'b0000 || getCnt(0) !== 2'd2) begin
      nMismatched++;
      $display("[TB] FAIL rmid_async_clear: got valid=%b cnt0=%0d expected valid=0000 cnt0=2",
               bus.out_valid_o, getCnt(0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NUM_OUT; k++) begin
      nCompared++;
      if (getCnt(k) !== 2'd2) begin
        nMismatched++; $display("[TB] FAIL rmid_credit%0d: got %0d expected 2", k, getCnt(k));
      end
    end
    sendWord(32'h77, '0);
    nCompared++;
    if (bus.out_valid_o !== 4'b0001 || bus.out_data_o !== 32'h77) begin
      nMismatched++;
      $display("[TB] FAIL rmid_next_port0: got valid=%b data=%h expected valid=0001 data=00000077",
               bus.out_valid_o, bus.out_data_o);
    end
  endtask

  initial begin
    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = '0;
    bus.credit_ret_i = '0;
    test_reset();
    test_back_to_back();
    test_skip_port();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/rr_credit_dispatcher.md
Name: rr_credit_dispatcher

Overview:
- Single-input, multi-output round-robin dispatcher. It is the 1-to-N counterpart of the team's N-to-1 round-robin arbiter.
- Accepts one valid/ready stream and distributes each word to one of NUM_OUT consumers in rotating order.
- Each consumer has a per-port credit counter, so a word is sent only to a port with buffer space.
- Sits in front of replicated processing lanes; the consumers return credits as they drain.

Parameters:
- NUM_OUT, 4, number of output ports (>=2).
- DATA_W, 32, data word width.
- CREDITS, 2, initial and maximum credits per port (>=1).
- CNT_W, $clog2(CREDITS+1), credit counter width (derived; do not override).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  input word valid.
- in_ready_o  output  1  dispatcher can accept a word this cycle.
- in_data_i  input  DATA_W  input word.
- out_valid_o  output  NUM_OUT  one-hot delivery strobe, single-cycle pulse per word.
- out_data_o  output  DATA_W  delivered word, shared by all ports; qualified by out_valid_o.
- credit_ret_i  input  NUM_OUT  per-port credit return; each set bit returns one credit.
- credit_cnt_o  output  NUM_OUT*CNT_W  current credit counts; port k at bits [k*CNT_W +: CNT_W].
- err_o  output  1  sticky credit-overflow error.

Behaviour:
- Reset values (async assert, sync deassert handled upstream):
  - all credits = CREDITS
  - base pointer = one-hot port 0
  - out_valid_o = 0
  - out_data_o = 0
  - err_o = 0
- Eligibility:
  - eligible[k] = (credit[k] != 0). Computed from registers only.
  - in_ready_o = |eligible. No combinational path from in_valid_i to in_ready_o.
- Fire:
  - fire = in_valid_i & in_ready_o.
  - Target = first eligible port at or above base, wrapping from NUM_OUT-1 to 0. Exactly one-hot.
- Output timing, latency 1 cycle:
  - On a fire cycle, the next cycle has out_valid_o = target and out_data_o = the captured in_data_i.
  - On a non-fire cycle, the next cycle has out_valid_o = 0 and out_data_o holds its last value.
  - There is no output-side ready; credits guarantee the consumer can take the word.
  - Back-to-back fires produce back-to-back pulses, giving full throughput while credits remain.
- Pointer:
  - On fire, base <= target rotated left by one, wrapping.
  - Without a fire, base is unchanged. Idle cycles do not rotate the pointer.
- Credits, per port k:
  - dec = fire & target[k]; inc = credit_ret_i[k].
  - dec & inc: credit unchanged (net zero, legal even at credit 1).
  - dec only: credit - 1. Cannot underflow, because only eligible ports are targeted.
  - inc only, credit < CREDITS: credit + 1.
  - inc only, credit == CREDITS: overflow. Credit stays at CREDITS and err_o <= 1.
  - A credit returned in cycle t makes the port eligible in cycle t+1, not cycle t.
- err_o stays high until reset. Dispatch continues normally after an overflow.
- in_data_i is a don't-care when there is no fire. in_valid_i may drop without a fire (no stability requirement is enforced on the input).
- Reset mid-operation:
  - Any pending output pulse is discarded: out_valid_o goes to 0 immediately on rst_ni low.
  - Credits, pointer and err_o return to their reset values.
- Assertions the bench checks:
  - $onehot0(out_valid_o) every cycle.
  - No fire when all credits are 0.
  - Sum of credits plus outstanding words (never returned) equals NUM_OUT*CREDITS, absent overflow.

Test Plan (NUM_OUT=4, CREDITS=2, DATA_W=32):
1. Release reset, in_valid_i=0 -> in_ready_o=1, out_valid_o=0, all credit_cnt_o fields = 2, err_o=0.
2. Drive 8 back-to-back words 0xA0..0xA7, no returns:
   - out_valid_o = 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000, each one cycle after its fire, with matching data.
   - in_ready_o=0 after the 8th fire.
3. From reset, pulse credit_ret_i... instead pre-drain port1 to 0 credits, then send 3 words -> grant order skips port1, e.g. base=0010 gives targets 0100, 1000, 0001.
4. Port2 at credit 1; fire targeting port2 in the same cycle as credit_ret_i[2]=1 -> credit_cnt for port2 remains 1 and err_o=0.
5. With port3 at credit 2, assert credit_ret_i[3]=1 -> credit stays 2, err_o=1 and stays 1. A following word still dispatches normally.
6. Assert rst_ni=0 the cycle after a fire -> out_valid_o=0 immediately. After release: credits=2, next word goes to port 0.
